// File: rtl/fpnew_issue_rob.sv
// fpnew_issue_rob: issue/reorder buffer in front of an out-of-order FPU.
//
// Requests pass combinationally to the FPU with a tag taken from the alloc pointer.
// Results come back in any order and are parked in the entry their tag names.
// Responses leave strictly in issue order from the retire pointer.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   flush_i                abort all in-flight ops (mirrored on fpu_flush_o)
//   req_*                  upstream request: valid/ready, {op1, op0}, op, op_mod, rnd
//   fpu_in_*, fpu_*_o      FPU issue side: valid/ready, operands, op, op_mod, rnd, tag
//   fpu_out_*, fpu_*_i     FPU result side: valid/ready, result, status, tag
//   rsp_*                  in-order response: valid/ready, result, status
//   busy_o                 at least one entry allocated
//   spurious_o             sticky: a result arrived for a tag that was not waiting for one
//   fflags_o, fflags_clr_i accumulated response status and its clear
//
// Build option: define FPNEW_ISSUE_FFLAGS_EN to accumulate status flags in fflags_o;
// without it fflags_o is tied to zero and fflags_clr_i is ignored.

module fpnew_issue_rob #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [2*WIDTH-1:0]                   req_operands_i,
    input  logic [3:0]                           req_op_i,
    input  logic                                 req_op_mod_i,
    input  logic [2:0]                           req_rnd_i,
    output logic                                 fpu_in_valid_o,
    input  logic                                 fpu_in_ready_i,
    output logic [2*WIDTH-1:0]                   fpu_operands_o,
    output logic [3:0]                           fpu_op_o,
    output logic                                 fpu_op_mod_o,
    output logic [2:0]                           fpu_rnd_o,
    output logic [$clog2(MAX_OUTSTANDING)-1:0]   fpu_tag_o,
    output logic                                 fpu_flush_o,
    input  logic                                 fpu_out_valid_i,
    output logic                                 fpu_out_ready_o,
    input  logic [WIDTH-1:0]                     fpu_result_i,
    input  logic [4:0]                           fpu_status_i,
    input  logic [$clog2(MAX_OUTSTANDING)-1:0]   fpu_tag_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [WIDTH-1:0]                     rsp_result_o,
    output logic [4:0]                           rsp_status_o,
    output logic                                 busy_o,
    output logic                                 spurious_o,
    output logic [4:0]                           fflags_o,
    input  logic                                 fflags_clr_i
);

    localparam int unsigned TAG_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(MAX_OUTSTANDING);

    logic [MAX_OUTSTANDING-1:0]            pending_q, pending_d;
    logic [MAX_OUTSTANDING-1:0]            done_q, done_d;
    logic [MAX_OUTSTANDING-1:0][WIDTH-1:0] result_q, result_d;
    logic [MAX_OUTSTANDING-1:0][4:0]       status_q, status_d;
    logic [TAG_W-1:0]                      alloc_q, alloc_d;
    logic [TAG_W-1:0]                      retire_q, retire_d;
    logic [CNT_W-1:0]                      count_q, count_d;
    logic                                  spurious_q, spurious_d;

    logic not_full;
    logic issue;
    logic res_hs;
    logic res_ok;
    logic retire;

    // Handshake decode and combinational pass-through.
    always_comb begin
        not_full        = (count_q != COUNT_FULL);
        fpu_in_valid_o  = req_valid_i & not_full & ~flush_i;
        req_ready_o     = fpu_in_ready_i & not_full & ~flush_i;
        issue           = req_valid_i & req_ready_o;
        fpu_operands_o  = req_operands_i;
        fpu_op_o        = req_op_i;
        fpu_op_mod_o    = req_op_mod_i;
        fpu_rnd_o       = req_rnd_i;
        fpu_tag_o       = alloc_q;
        fpu_flush_o     = flush_i;
        fpu_out_ready_o = ~rst_i & ~flush_i;
        res_hs          = fpu_out_valid_i & fpu_out_ready_o;
        res_ok          = pending_q[fpu_tag_i] & ~done_q[fpu_tag_i];
        rsp_valid_o     = done_q[retire_q];
        rsp_result_o    = result_q[retire_q];
        rsp_status_o    = status_q[retire_q];
        retire          = rsp_valid_o & rsp_ready_i & ~flush_i;
        busy_o          = (count_q != '0);
        spurious_o      = spurious_q;
    end

    // Next-state for the entry array, pointers and occupancy.
    always_comb begin
        pending_d  = pending_q;
        done_d     = done_q;
        result_d   = result_q;
        status_d   = status_q;
        alloc_d    = alloc_q;
        retire_d   = retire_q;
        count_d    = count_q;
        spurious_d = spurious_q;

        // A retiring entry is already done, so a result aimed at it is spurious and can
        // never collide with the clear below. Likewise issue never targets the retire slot
        // because that only happens when full.
        if (res_hs) begin
            if (res_ok) begin
                done_d[fpu_tag_i]   = 1'b1;
                result_d[fpu_tag_i] = fpu_result_i;
                status_d[fpu_tag_i] = fpu_status_i;
            end else begin
                spurious_d = 1'b1;
            end
        end

        if (retire) begin
            pending_d[retire_q] = 1'b0;
            done_d[retire_q]    = 1'b0;
            retire_d            = retire_q + TAG_W'(1);
        end

        if (issue) begin
            pending_d[alloc_q] = 1'b1;
            done_d[alloc_q]    = 1'b0;
            alloc_d            = alloc_q + TAG_W'(1);
        end

        unique case ({issue, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            pending_d = '0;
            done_d    = '0;
            alloc_d   = '0;
            retire_d  = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            done_q     <= '0;
            result_q   <= '0;
            status_q   <= '0;
            alloc_q    <= '0;
            retire_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            done_q     <= done_d;
            result_q   <= result_d;
            status_q   <= status_d;
            alloc_q    <= alloc_d;
            retire_q   <= retire_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
        end
    end

`ifdef FPNEW_ISSUE_FFLAGS_EN
    logic [4:0] fflags_q, fflags_d;

    // The clear applies first so flags of a same-cycle response survive it.
    always_comb begin
        fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
        if (retire) begin
            fflags_d = fflags_d | rsp_status_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_o = fflags_q;
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr_i;
    assign fflags_o          = '0;
`endif

endmodule
